// File: rtl/stream_mux_rr.sv
// stream_mux_rr: registered N-way valid/ready stream mux, select or round-robin arbitration
module stream_mux_rr #(
   parameter int WIDTH    = 16,
   parameter int CHANNELS = 4,
   parameter int MODE     = 0,
   localparam int SELW    = CHANNELS > 1 ? $clog2(CHANNELS) : 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [CHANNELS*WIDTH-1:0] in_data,
   input  logic [CHANNELS-1:0]       in_valid,
   output logic [CHANNELS-1:0]       in_ready,
   input  logic [SELW-1:0]           sel,
   output logic [WIDTH-1:0]          out_data,
   output logic [SELW-1:0]           out_chan,
   output logic                      out_valid,
   input  logic                      out_ready
);
   logic [SELW-1:0]     ptr;
   logic [SELW-1:0]     g_idx;
   logic [CHANNELS-1:0] grant;
   logic [WIDTH-1:0]    g_data;
   logic                load_en;
   logic                xfer;

   assign load_en  = !out_valid || out_ready;
   assign in_ready = grant & {CHANNELS{load_en}};
   assign xfer     = |grant && load_en;

   // grant the selected channel, or the first valid channel scanning from ptr
   always_comb begin
      int k;
      k      = 0;
      grant  = '0;
      g_idx  = '0;
      g_data = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         k = MODE == 1 ? (int'(ptr) + i) % CHANNELS : i;
         if (grant == '0 && in_valid[k] && (MODE == 1 || int'(sel) == i)) begin
            grant[k] = 1'b1;
            g_idx    = SELW'(k);
            g_data   = in_data[k*WIDTH +: WIDTH];
         end
      end
   end

   // priority pointer moves just past the channel that transferred, wrapping at CHANNELS
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)
         ptr <= '0;
      else if (MODE == 1 && xfer)
         ptr <= int'(g_idx) == CHANNELS - 1 ? '0 : g_idx + SELW'(1);

   // output register: load on transfer, empty on idle drain, hold while stalled
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_chan  <= '0;
      end else if (load_en) begin
         out_valid <= xfer;
         if (xfer) begin
            out_data <= g_data;
            out_chan <= g_idx;
         end
      end
endmodule

// File: tb/tb_stream_mux_rr.sv
// tb_stream_mux_rr: directed checks of select mode, round-robin, backpressure, wrap and reset
module tb_stream_mux_rr;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int tests = 0;
   int fails = 0;

   logic [63:0] d0, d1;
   logic [47:0] d2, d3;
   logic [3:0]  v0, v1, r0, r1;
   logic [2:0]  v2, v3, r2, r3;
   logic [1:0]  s0, s1, s2, s3, oc0, oc1, oc2, oc3;
   logic [15:0] od0, od1, od2, od3;
   logic        ov0, ov1, ov2, ov3;
   logic        ordy0, ordy1, ordy2, ordy3;

   always #5 clk = ~clk;

   stream_mux_rr #(.WIDTH(16), .CHANNELS(4), .MODE(0)) u0 (
      .clk(clk), .rst_n(rst_n), .in_data(d0), .in_valid(v0), .in_ready(r0), .sel(s0),
      .out_data(od0), .out_chan(oc0), .out_valid(ov0), .out_ready(ordy0));
   stream_mux_rr #(.WIDTH(16), .CHANNELS(4), .MODE(1)) u1 (
      .clk(clk), .rst_n(rst_n), .in_data(d1), .in_valid(v1), .in_ready(r1), .sel(s1),
      .out_data(od1), .out_chan(oc1), .out_valid(ov1), .out_ready(ordy1));
   stream_mux_rr #(.WIDTH(16), .CHANNELS(3), .MODE(0)) u2 (
      .clk(clk), .rst_n(rst_n), .in_data(d2), .in_valid(v2), .in_ready(r2), .sel(s2),
      .out_data(od2), .out_chan(oc2), .out_valid(ov2), .out_ready(ordy2));
   stream_mux_rr #(.WIDTH(16), .CHANNELS(3), .MODE(1)) u3 (
      .clk(clk), .rst_n(rst_n), .in_data(d3), .in_valid(v3), .in_ready(r3), .sel(s3),
      .out_data(od3), .out_chan(oc3), .out_valid(ov3), .out_ready(ordy3));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      d0 = {16'h4444, 16'hBEEF, 16'h2222, 16'h1111};
      d1 = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
      d2 = {16'h3333, 16'h2222, 16'h1111};
      d3 = {16'h3333, 16'h2222, 16'h1111};
      {v0, v1, v2, v3} = '0;
      {s0, s1, s2, s3} = '0;
      {ordy0, ordy1, ordy2, ordy3} = 4'hF;
      #1;
      chk("rst ov", 32'(ov0), 0);
      chk("rst od", 32'(od0), 0);
      chk("rst oc", 32'(oc0), 0);
      v0 = 4'hF;
      s0 = 2'd2;
      #1;
      chk("rst in_ready=grant", 32'(r0), 32'b0100);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      chk("sel2 od", 32'(od0), 32'hBEEF);
      chk("sel2 oc", 32'(oc0), 2);
      chk("sel2 ov", 32'(ov0), 1);
      s0 = 2'd0;
      step();
      chk("sel0 od", 32'(od0), 32'h1111);
      chk("sel0 oc", 32'(oc0), 0);
      v0 = 4'h0;
      step();
      chk("idle ov", 32'(ov0), 0);
      chk("idle od hold", 32'(od0), 32'h1111);

      // round-robin, all valid, sel ignored
      v1 = 4'hF;
      s1 = 2'd3;
      for (int i = 0; i < 6; i++) begin
         step();
         chk("rr oc", 32'(oc1), 32'(i % 4));
         chk("rr ov", 32'(ov1), 1);
         chk("rr od", 32'(od1), 32'h1111 * 32'((i % 4) + 1));
      end
      v1 = 4'b0100;
      step();
      chk("rr to ptr3", 32'(oc1), 2);
      v1 = 4'b0010;
      #1;
      chk("ptr3 ch1 ready", 32'(r1), 32'b0010);
      step();
      chk("ptr3 ch1 grant", 32'(oc1), 1);
      v1 = 4'b0101;
      #1;
      chk("ptr2 ready ch2", 32'(r1), 32'b0100);
      step();
      chk("ptr2 grant ch2", 32'(oc1), 2);
      #1;
      chk("ptr3 ready ch0", 32'(r1), 32'b0001);
      step();
      chk("ptr3 grant ch0", 32'(oc1), 0);
      chk("ptr3 od ch0", 32'(od1), 32'h1111);

      // backpressure on u0
      d0[31:16] = 16'h1234;
      s0 = 2'd1;
      v0 = 4'hF;
      step();
      chk("bp load", 32'(od0), 32'h1234);
      ordy0 = 1'b0;
      d0[31:16] = 16'h5678;
      s0 = 2'd3;
      #1;
      chk("bp ready0", 32'(r0), 0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("bp hold od", 32'(od0), 32'h1234);
         chk("bp hold ov", 32'(ov0), 1);
         chk("bp hold ready", 32'(r0), 0);
      end
      ordy0 = 1'b1;
      #1;
      chk("bp drain ready", 32'(r0), 32'b1000);
      step();
      chk("bp reload od", 32'(od0), 32'h4444);
      chk("bp reload oc", 32'(oc0), 3);
      chk("bp reload ov", 32'(ov0), 1);
      v0 = 4'h0;
      step();
      chk("bp empty", 32'(ov0), 0);

      // three channels, select out of range
      v2 = 3'b111;
      s2 = 2'd3;
      #1;
      chk("c3 sel3 ready", 32'(r2), 0);
      step();
      chk("c3 sel3 ov", 32'(ov2), 0);
      step();
      chk("c3 sel3 ov2", 32'(ov2), 0);
      s2 = 2'd2;
      #1;
      chk("c3 sel2 ready", 32'(r2), 32'b100);
      step();
      chk("c3 sel2 od", 32'(od2), 32'h3333);
      chk("c3 sel2 oc", 32'(oc2), 2);

      // three channels, round-robin wrap at 3
      v3 = 3'b010;
      step();
      chk("c3rr ch1", 32'(oc3), 1);
      v3 = 3'b011;
      #1;
      chk("c3rr wrap ready", 32'(r3), 32'b001);
      step();
      chk("c3rr wrap ch0", 32'(oc3), 0);
      chk("c3rr wrap od", 32'(od3), 32'h1111);
      v3 = 3'b111;
      step();
      chk("c3rr seq1", 32'(oc3), 1);
      step();
      chk("c3rr seq2", 32'(oc3), 2);
      step();
      chk("c3rr seq0", 32'(oc3), 0);
      v3 = 3'b000;

      // reset mid-stream drops held word and resets ptr
      d1[31:16] = 16'hAAAA;
      v1 = 4'b0010;
      #1;
      chk("pre-rst ready", 32'(r1), 32'b0010);
      step();
      chk("pre-rst od", 32'(od1), 32'hAAAA);
      chk("pre-rst oc", 32'(oc1), 1);
      ordy1 = 1'b0;
      v1 = 4'h0;
      step();
      chk("pre-rst hold", 32'(od1), 32'hAAAA);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst ov", 32'(ov1), 0);
      chk("midrst od", 32'(od1), 0);
      chk("midrst oc", 32'(oc1), 0);
      v1 = 4'hF;
      ordy1 = 1'b1;
      #1;
      chk("midrst ready", 32'(r1), 32'b0001);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      chk("postrst oc", 32'(oc1), 0);
      chk("postrst od", 32'(od1), 32'h1111);
      chk("postrst ov", 32'(ov1), 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
endmodule
